// File: rtl/pc_sequencer.sv
// Registered program counter with next-PC selection, stall hold, misaligned-target trap
// and a circular return-address stack that counts return mispredictions.
module pc_sequencer #(
  parameter int unsigned        ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  RESET_VEC = '0,
  parameter logic [ADDR_W-1:0]  TRAP_VEC  = ADDR_W'(32'h0000_0180),
  parameter int unsigned        RAS_DEPTH = 4,
  parameter int unsigned        CNT_W     = 8
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              stall_i,
  input  logic              branch_i,
  input  logic              zero_i,
  input  logic              jmp_i,
  input  logic              jr_i,
  input  logic              link_i,
  input  logic              ret_i,
  input  logic [ADDR_W-1:0] rs_i,
  input  logic [ADDR_W-1:0] expand_i,
  input  logic [31:0]       instruction_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pc_add4_c_o,
  output logic [ADDR_W-1:0] epc_o,
  output logic              trap_o,
  output logic              trap_err_o,
  output logic              ras_miss_o,
  output logic [CNT_W-1:0]  mis_cnt_o
);

  localparam int unsigned PTR_W  = $clog2(RAS_DEPTH);
  localparam int unsigned RCNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic              trap_q, trap_d;
  logic              err_q, err_d;
  logic              miss_q, miss_d;
  logic [CNT_W-1:0]  mcnt_q, mcnt_d;
  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
  logic [ADDR_W-1:0] ras_d [RAS_DEPTH];
  logic [PTR_W-1:0]  top_q, top_d, top_inc;
  logic [RCNT_W-1:0] rcnt_q, rcnt_d;

  logic [ADDR_W-1:0] pc_add4, br_addr, j_addr, target;
  logic              misalign, take_trap, push, pop, ras_empty, pop_miss;
  logic              unused_instr;

  assign unused_instr = ^instruction_i[31:26];

  // Target calculation and priority selection: jr > jmp > taken branch > sequential
  always_comb begin
    pc_add4 = pc_q + ADDR_W'(4);
    br_addr = pc_add4 + (expand_i << 2);
    j_addr  = (pc_add4 & ~ADDR_W'(32'h0FFF_FFFF)) | ADDR_W'({instruction_i[25:0], 2'b00});
    target  = pc_add4;
    if (jmp_i || jr_i)          target = jr_i ? rs_i : j_addr;
    else if (branch_i && zero_i) target = br_addr;
  end

  assign misalign  = |target[1:0];
  assign take_trap = !stall_i && misalign;
  assign push      = jmp_i && link_i && !stall_i && !misalign;
  assign pop       = jr_i && ret_i && !stall_i && !misalign;
  assign ras_empty = (rcnt_q == '0);
  assign pop_miss  = pop && (ras_empty || (ras_q[top_q] != rs_i));
  assign top_inc   = top_q + PTR_W'(1);

  // Circular stack: a push onto a full stack wraps over the oldest entry
  always_comb begin
    ras_d  = ras_q;
    top_d  = top_q;
    rcnt_d = rcnt_q;
    if (push && pop) begin
      ras_d[top_q] = pc_add4;
      if (ras_empty) rcnt_d = RCNT_W'(1);
    end else if (push) begin
      if (ras_empty) begin
        ras_d[top_q] = pc_add4;
        rcnt_d       = RCNT_W'(1);
      end else begin
        top_d          = top_inc;
        ras_d[top_inc] = pc_add4;
        if (rcnt_q != RCNT_W'(RAS_DEPTH)) rcnt_d = rcnt_q + RCNT_W'(1);
      end
    end else if (pop && !ras_empty) begin
      top_d  = top_q - PTR_W'(1);
      rcnt_d = rcnt_q - RCNT_W'(1);
    end
  end

  always_comb begin
    pc_d   = pc_q;
    epc_d  = epc_q;
    trap_d = take_trap;
    err_d  = err_q | take_trap;
    miss_d = pop_miss;
    mcnt_d = mcnt_q;
    if (!stall_i) pc_d = take_trap ? TRAP_VEC : target;
    if (take_trap) epc_d = pc_q;
    if (pop_miss && (mcnt_q != '1)) mcnt_d = mcnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      pc_q   <= RESET_VEC;
      epc_q  <= '0;
      trap_q <= 1'b0;
      err_q  <= 1'b0;
      miss_q <= 1'b0;
      mcnt_q <= '0;
      top_q  <= '0;
      rcnt_q <= '0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) ras_q[i] <= '0;
    end else begin
      pc_q   <= pc_d;
      epc_q  <= epc_d;
      trap_q <= trap_d;
      err_q  <= err_d;
      miss_q <= miss_d;
      mcnt_q <= mcnt_d;
      top_q  <= top_d;
      rcnt_q <= rcnt_d;
      ras_q  <= ras_d;
    end
  end

  assign pc_o        = pc_q;
  assign pc_add4_c_o = pc_add4;
  assign epc_o       = epc_q;
  assign trap_o      = trap_q;
  assign trap_err_o  = err_q;
  assign ras_miss_o  = miss_q;
  assign mis_cnt_o   = mcnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer; a second instance with a 2-bit
// mismatch counter shares the stimulus to exercise saturation.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall, branch, zero, jmp, jr, link, ret;
  logic [31:0] rs, expand, instruction;
  logic [31:0] pc, pc_add4, epc, pc2, pc_add4_2, epc2;
  logic        trap, trap_err, ras_miss, trap2, trap_err2, ras_miss2;
  logic [7:0]  mis_cnt;
  logic [1:0]  mis_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk_i(clk), .reset_ni(reset_n), .stall_i(stall), .branch_i(branch), .zero_i(zero),
    .jmp_i(jmp), .jr_i(jr), .link_i(link), .ret_i(ret), .rs_i(rs), .expand_i(expand),
    .instruction_i(instruction), .pc_o(pc), .pc_add4_c_o(pc_add4), .epc_o(epc),
    .trap_o(trap), .trap_err_o(trap_err), .ras_miss_o(ras_miss), .mis_cnt_o(mis_cnt)
  );

  pc_sequencer #(.CNT_W(2)) dut2 (
    .clk_i(clk), .reset_ni(reset_n), .stall_i(stall), .branch_i(branch), .zero_i(zero),
    .jmp_i(jmp), .jr_i(jr), .link_i(link), .ret_i(ret), .rs_i(rs), .expand_i(expand),
    .instruction_i(instruction), .pc_o(pc2), .pc_add4_c_o(pc_add4_2), .epc_o(epc2),
    .trap_o(trap2), .trap_err_o(trap_err2), .ras_miss_o(ras_miss2), .mis_cnt_o(mis_cnt2)
  );

  typedef struct {
    logic        st, br, z, j, r, lk, rt;
    logic [31:0] rs, ex;
    logic [25:0] idx;
    logic [31:0] e_pc, e_epc;
    logic        e_trap, e_err, e_miss;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic st, br, z, j, r, lk, rt,
                             input logic [31:0] rsv, exv, input logic [25:0] idx,
                             input logic [31:0] e_pc, e_epc,
                             input logic e_trap, e_err, e_miss, input logic [7:0] e_cnt);
    vec_t t;
    t.st = st; t.br = br; t.z = z; t.j = j; t.r = r; t.lk = lk; t.rt = rt;
    t.rs = rsv; t.ex = exv; t.idx = idx;
    t.e_pc = e_pc; t.e_epc = e_epc; t.e_trap = e_trap; t.e_err = e_err;
    t.e_miss = e_miss; t.e_cnt = e_cnt;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    stall = 0; branch = 0; zero = 0; jmp = 0; jr = 0; link = 0; ret = 0;
    rs = '0; expand = '0; instruction = '0;
  endtask

  task automatic check_outputs(input string tag, input logic [31:0] e_pc, e_epc,
                               input logic e_trap, e_err, e_miss, input logic [7:0] e_cnt);
    logic [7:0] e_cnt2;
    e_cnt2 = (e_cnt > 8'd3) ? 8'd3 : e_cnt;
    chk({tag, " pc"}, pc, e_pc);
    chk({tag, " pc_add4"}, pc_add4, e_pc + 32'd4);
    chk({tag, " epc"}, epc, e_epc);
    chk({tag, " trap"}, 32'(trap), 32'(e_trap));
    chk({tag, " trap_err"}, 32'(trap_err), 32'(e_err));
    chk({tag, " ras_miss"}, 32'(ras_miss), 32'(e_miss));
    chk({tag, " mis_cnt"}, 32'(mis_cnt), 32'(e_cnt));
    chk({tag, " mis_cnt_w2"}, 32'(mis_cnt2), 32'(e_cnt2));
  endtask

  task automatic apply(input vec_t t, input int n);
    stall = t.st; branch = t.br; zero = t.z; jmp = t.j; jr = t.r; link = t.lk; ret = t.rt;
    rs = t.rs; expand = t.ex; instruction = {6'b0, t.idx};
    @(posedge clk);
    #1;
    check_outputs($sformatf("step%0d", n), t.e_pc, t.e_epc, t.e_trap, t.e_err, t.e_miss, t.e_cnt);
  endtask

  initial begin
    // st br z j r lk rt  rs  expand  idx  pc  epc  trap err miss cnt
    tbl.push_back(v(0,0,0,0,0,0,0, 32'h0, 32'h0, 26'h0, 32'h4, 32'h0, 0,0,0, 8'd0));
    tbl.push_back(v(0,0,0,0,0,0,0, 32'h0, 32'h0, 26'h0, 32'h8, 32'h0, 0,0,0, 8'd0));
    tbl.push_back(v(0,0,0,0,0,0,0, 32'h0, 32'h0, 26'h0, 32'hC, 32'h0, 0,0,0, 8'd0));
    tbl.push_back(v(0,0,0,0,0,0,0, 32'h0, 32'h0, 26'h0, 32'h10, 32'h0, 0,0,0, 8'd0));
    tbl.push_back(v(0,1,1,0,0,0,0, 32'h0, 32'hFFFF_FFFE, 26'h0, 32'hC, 32'h0, 0,0,0, 8'd0));
    tbl.push_back(v(0,1,1,0,1,0,0, 32'h40, 32'hFFFF_FFFE, 26'h0, 32'h40, 32'h0, 0,0,0, 8'd0));
    tbl.push_back(v(1,1,1,0,1,0,0, 32'h44, 32'hFFFF_FFFE, 26'h0, 32'h40, 32'h0, 0,0,0, 8'd0));
    tbl.push_back(v(0,1,0,0,0,0,0, 32'h0, 32'h5, 26'h0, 32'h44, 32'h0, 0,0,0, 8'd0));
    tbl.push_back(v(0,0,0,1,1,0,0, 32'h20, 32'h0, 26'h40, 32'h20, 32'h0, 0,0,0, 8'd0));
    tbl.push_back(v(0,0,0,0,1,0,0, 32'h42, 32'h0, 26'h0, 32'h180, 32'h20, 1,1,0, 8'd0));
    tbl.push_back(v(0,0,0,0,0,0,0, 32'h0, 32'h0, 26'h0, 32'h184, 32'h20, 0,1,0, 8'd0));
    tbl.push_back(v(1,0,0,0,1,0,0, 32'h43, 32'h0, 26'h0, 32'h184, 32'h20, 0,1,0, 8'd0));
    tbl.push_back(v(0,0,0,1,0,0,0, 32'h0, 32'h0, 26'h40, 32'h100, 32'h20, 0,1,0, 8'd0));
    tbl.push_back(v(0,0,0,1,0,1,0, 32'h0, 32'h0, 26'h80, 32'h200, 32'h20, 0,1,0, 8'd0));
    tbl.push_back(v(0,0,0,1,0,1,0, 32'h0, 32'h0, 26'hC0, 32'h300, 32'h20, 0,1,0, 8'd0));
    tbl.push_back(v(0,0,0,1,0,1,0, 32'h0, 32'h0, 26'h100, 32'h400, 32'h20, 0,1,0, 8'd0));
    tbl.push_back(v(0,0,0,1,0,1,0, 32'h0, 32'h0, 26'h140, 32'h500, 32'h20, 0,1,0, 8'd0));
    tbl.push_back(v(0,0,0,1,0,1,0, 32'h0, 32'h0, 26'h180, 32'h600, 32'h20, 0,1,0, 8'd0));
    tbl.push_back(v(0,0,0,0,1,0,1, 32'h504, 32'h0, 26'h0, 32'h504, 32'h20, 0,1,0, 8'd0));
    tbl.push_back(v(0,0,0,0,1,0,1, 32'h404, 32'h0, 26'h0, 32'h404, 32'h20, 0,1,0, 8'd0));
    tbl.push_back(v(0,0,0,0,1,0,1, 32'h304, 32'h0, 26'h0, 32'h304, 32'h20, 0,1,0, 8'd0));
    tbl.push_back(v(0,0,0,0,1,0,1, 32'h204, 32'h0, 26'h0, 32'h204, 32'h20, 0,1,0, 8'd0));
    tbl.push_back(v(0,0,0,0,1,0,1, 32'h104, 32'h0, 26'h0, 32'h104, 32'h20, 0,1,1, 8'd1));
    tbl.push_back(v(0,0,0,0,0,0,0, 32'h0, 32'h0, 26'h0, 32'h108, 32'h20, 0,1,0, 8'd1));
    tbl.push_back(v(0,0,0,1,0,1,0, 32'h0, 32'h0, 26'h200, 32'h800, 32'h20, 0,1,0, 8'd1));
    tbl.push_back(v(0,0,0,0,1,0,1, 32'h900, 32'h0, 26'h0, 32'h900, 32'h20, 0,1,1, 8'd2));
    tbl.push_back(v(1,0,0,0,1,0,1, 32'h900, 32'h0, 26'h0, 32'h900, 32'h20, 0,1,0, 8'd2));
    tbl.push_back(v(0,0,0,0,0,1,1, 32'h0, 32'h0, 26'h0, 32'h904, 32'h20, 0,1,0, 8'd2));
    tbl.push_back(v(0,0,0,1,0,1,0, 32'h0, 32'h0, 26'h300, 32'hC00, 32'h20, 0,1,0, 8'd2));
    tbl.push_back(v(0,0,0,1,1,1,1, 32'h908, 32'h0, 26'h0, 32'h908, 32'h20, 0,1,0, 8'd2));
    tbl.push_back(v(0,0,0,0,1,0,1, 32'hC04, 32'h0, 26'h0, 32'hC04, 32'h20, 0,1,0, 8'd2));
    tbl.push_back(v(0,0,0,0,1,0,1, 32'h904, 32'h0, 26'h0, 32'h904, 32'h20, 0,1,1, 8'd3));
    tbl.push_back(v(0,0,0,0,1,0,1, 32'h1000, 32'h0, 26'h0, 32'h1000, 32'h20, 0,1,1, 8'd4));
    tbl.push_back(v(0,0,0,0,1,0,1, 32'h2000, 32'h0, 26'h0, 32'h2000, 32'h20, 0,1,1, 8'd5));
    tbl.push_back(v(0,0,0,0,1,0,0, 32'hFFFF_FFFC, 32'h0, 26'h0, 32'hFFFF_FFFC, 32'h20, 0,1,0, 8'd5));
    tbl.push_back(v(0,0,0,0,0,0,0, 32'h0, 32'h0, 26'h0, 32'h0, 32'h20, 0,1,0, 8'd5));
    tbl.push_back(v(0,0,0,1,0,1,0, 32'h0, 32'h0, 26'h40, 32'h100, 32'h20, 0,1,0, 8'd5));
    tbl.push_back(v(0,0,0,1,0,1,0, 32'h0, 32'h0, 26'h80, 32'h200, 32'h20, 0,1,0, 8'd5));
    tbl.push_back(v(0,0,0,1,0,1,0, 32'h0, 32'h0, 26'hC0, 32'h300, 32'h20, 0,1,0, 8'd5));
    tbl.push_back(v(0,0,0,1,0,1,0, 32'h0, 32'h0, 26'h100, 32'h400, 32'h20, 0,1,0, 8'd5));
    tbl.push_back(v(0,0,0,0,1,0,0, 32'h2, 32'h0, 26'h0, 32'h180, 32'h400, 1,1,0, 8'd5));

    reset_n = 1'b0;
    drive_idle();
    #12;
    check_outputs("reset", 32'h0, 32'h0, 0, 0, 0, 8'd0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (tbl[i]) apply(tbl[i], i + 1);

    // Asynchronous reset in the middle of a cycle, with a full stack and a sticky error
    drive_idle();
    #2;
    reset_n = 1'b0;
    #1;
    check_outputs("async_reset", 32'h0, 32'h0, 0, 0, 0, 8'd0);
    @(negedge clk);
    reset_n = 1'b1;
    // Stack must be empty again: the first return misses
    apply(v(0,0,0,0,1,0,1, 32'h40, 32'h0, 26'h0, 32'h40, 32'h0, 0,0,1, 8'd1), 100);
    drive_idle();
    apply(v(0,0,0,0,0,0,0, 32'h0, 32'h0, 26'h0, 32'h44, 32'h0, 0,0,0, 8'd1), 101);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
